// File: rtl/mag_comp_pkg.sv
// Shared constants and FSM encoding for the min/max scan controller.
package mag_comp_pkg;

    // Sample width, tied to the 4-bit comparator.
    localparam int WIDTH = 4;

    // Scan controller states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_CMP_MAX = 3'd2,
        S_CMP_MIN = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Result values before any sample has been seen.
    localparam logic [WIDTH-1:0] MAX_RST = 4'h0;
    localparam logic [WIDTH-1:0] MIN_RST = 4'hF;

endpackage

// File: rtl/mag_comp_scan_ctrl_bit4_mag_comp.sv
// 4-bit unsigned magnitude comparator: A versus B.
module Bit4_mag_comp (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       Equal,
    output logic       Greater,
    output logic       Small
);

    // Purely combinational relation of A to B.
    always_comb begin
        Equal   = (A == B);
        Greater = (A > B);
        Small   = (A < B);
    end

endmodule

// File: rtl/mag_comp_scan_ctrl.sv
// Block min/max scanner: accepts len samples over valid/ready and tracks
// the running maximum and minimum (and first-occurrence index of each)
// using one shared comparator, one compare per cycle.
//
// Handshake: a sample transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in WAIT and does not
// depend on in_valid. The source must hold in_data stable while in_valid
// is high and not yet accepted.
module mag_comp_scan_ctrl
    import mag_comp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] min_idx,
    output logic [2:0]       dbg_state,
    output logic [2:0]       dbg_cmp
);

    state_t           state;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] sample_r;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             cmp_lt;

    // Operand B selects the running minimum only while comparing for it.
    always_comb begin
        cmp_b = (state == S_CMP_MIN) ? min_val : max_val;
    end

    Bit4_mag_comp u_cmp (
        .A       (sample_r),
        .B       (cmp_b),
        .Equal   (cmp_eq),
        .Greater (cmp_gt),
        .Small   (cmp_lt)
    );

    assign dbg_state = state;
    assign dbg_cmp   = {cmp_gt, cmp_eq, cmp_lt};

    // Control FSM with registered handshake/status outputs and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            max_val  <= MAX_RST;
            min_val  <= MIN_RST;
            max_idx  <= '0;
            min_idx  <= '0;
            len_r    <= '0;
            idx      <= '0;
            sample_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_r   <= len;
                        idx     <= '0;
                        max_val <= MAX_RST;
                        min_val <= MIN_RST;
                        max_idx <= '0;
                        min_idx <= '0;
                        busy    <= 1'b1;
                        if (len == '0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= S_WAIT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (in_valid && in_ready) begin
                        if (idx == '0) begin
                            // First sample seeds both extremes.
                            max_val <= in_data;
                            min_val <= in_data;
                            max_idx <= '0;
                            min_idx <= '0;
                            if (len_r == CNT_W'(1)) begin
                                state    <= S_DONE;
                                done     <= 1'b1;
                                in_ready <= 1'b0;
                            end else begin
                                idx <= CNT_W'(1);
                            end
                        end else begin
                            sample_r <= in_data;
                            state    <= S_CMP_MAX;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_CMP_MAX: begin
                    // Strict compare: a tie keeps the earlier index.
                    if (cmp_gt) begin
                        max_val <= sample_r;
                        max_idx <= idx;
                    end
                    state <= S_CMP_MIN;
                end
                S_CMP_MIN: begin
                    if (cmp_lt) begin
                        min_val <= sample_r;
                        min_idx <= idx;
                    end
                    if (idx == len_r - CNT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx      <= idx + CNT_W'(1);
                        state    <= S_WAIT;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
